// File: rtl/hyperram_pkg.sv
// Shared types and the CA-word builder for the HyperRAM command scheduler.
package hyperram_pkg;

   localparam int OP_NUM = 4;

   typedef enum logic [1:0] {
      OP_RDREG = 2'd0,
      OP_WRMEM = 2'd1,
      OP_WRREG = 2'd2,
      OP_RDMEM = 2'd3
   } hr_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_BUSY   = 2'd2,
      ST_GAP    = 2'd3
   } sched_state_e;

   // CA[47]=read, CA[46]=register space, CA[45]=burst type, split word address.
   function automatic logic [47:0] build_ca(hr_op_e op, logic [31:0] addr, logic linear);
      logic [47:0] ca;
      ca        = 48'd0;
      ca[47]    = (op == OP_RDREG) || (op == OP_RDMEM);
      ca[46]    = (op == OP_RDREG) || (op == OP_WRREG);
      ca[45]    = linear;
      ca[44:16] = addr[31:3];
      ca[2:0]   = addr[2:0];
      return ca;
   endfunction

endpackage

// File: rtl/hyperram_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last requester granted.
module hyperram_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       take,
   output logic       grant,
   output logic       grant_any
);

   logic ptr_q;
   logic ptr_d;

   assign grant_any = |valid;

   // Pointer starts at 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b1;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Grant selection and pointer update on an accepted request.
   always_comb begin
      grant = 1'b0;
      case (valid)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~ptr_q;
         default: grant = 1'b0;
      endcase
      if (take) begin
         ptr_d = grant;
      end else begin
         ptr_d = ptr_q;
      end
   end

endmodule

// File: rtl/hyperram_cmd_sched.sv
// Command scheduler: arbitrates two requesters, launches one HyperRAM engine at a time,
// muxes its bus onto the PHY and enforces the CS# gap and a per-transaction watchdog.
module hyperram_cmd_sched
   import hyperram_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter bit LINEAR_BURST   = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [3:0]          req_op,
   input  logic [2*ADDR_W-1:0] req_addr,
   output logic [1:0]          rsp_done,
   output logic                rsp_err,
   output logic [47:0]         eng_casig,
   output logic [3:0]          eng_start,
   input  logic [3:0]          eng_end,
   output logic                eng_rst,
   input  logic [3:0]          eng_csn,
   input  logic [3:0]          eng_oe,
   input  logic [3:0]          eng_oe_clk,
   input  logic [63:0]         eng_datain,
   input  logic                eng_rwds_out,
   input  logic                eng_rwds_oe,
   output logic                phy_csn,
   output logic                phy_oe,
   output logic                phy_oe_clk,
   output logic [15:0]         phy_datain,
   output logic                phy_rwds_out,
   output logic                phy_rwds_oe
);

   localparam int CNT_W = 16;

   sched_state_e      state_q, state_d;
   hr_op_e            op_q, op_d;
   logic              g_q, g_d;
   logic [47:0]       casig_q, casig_d;
   logic [3:0]        start_q, start_d;
   logic [1:0]        done_q, done_d;
   logic              err_q, err_d;
   logic              erst_q, erst_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              grant_s, grant_any_s, take_s;
   logic [1:0]        op_sel_s, op_idx_s;
   logic [31:0]       addr_sel_s;
   logic              end_sel_s, wd_exp_s, gap_end_s;

   hyperram_rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid     (req_valid),
      .take      (take_s),
      .grant     (grant_s),
      .grant_any (grant_any_s)
   );

   assign take_s    = (state_q == ST_IDLE) && grant_any_s;
   assign op_sel_s  = grant_s ? req_op[3:2] : req_op[1:0];
   assign op_idx_s  = op_q;
   assign end_sel_s = eng_end[op_idx_s];
   assign wd_exp_s  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign gap_end_s = (cnt_q == CNT_W'(GAP_CYCLES - 1));

   assign eng_casig = casig_q;
   assign eng_start = start_q;
   assign rsp_done  = done_q;
   assign rsp_err   = err_q;
   assign eng_rst   = erst_q;

   // Zero-extend the granted requester's address to 32 bits.
   always_comb begin
      addr_sel_s             = 32'd0;
      addr_sel_s[ADDR_W-1:0] = grant_s ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; an engine end takes precedence over watchdog expiry.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = take_s ? ST_LAUNCH : ST_IDLE;
         ST_LAUNCH: state_d = ST_BUSY;
         ST_BUSY:   state_d = (end_sel_s || wd_exp_s) ? ST_GAP : ST_BUSY;
         ST_GAP:    state_d = gap_end_s ? ST_IDLE : ST_GAP;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Registered outputs and transaction context; one counter serves as watchdog and gap timer.
   always_comb begin
      g_d     = g_q;
      op_d    = op_q;
      casig_d = casig_q;
      start_d = 4'd0;
      done_d  = 2'd0;
      err_d   = 1'b0;
      erst_d  = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (take_s) begin
               g_d     = grant_s;
               op_d    = hr_op_e'(op_sel_s);
               casig_d = build_ca(hr_op_e'(op_sel_s), addr_sel_s, LINEAR_BURST);
               start_d = 4'b0001 << op_sel_s;
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_LAUNCH: cnt_d = {CNT_W{1'b0}};
         ST_BUSY: begin
            if (end_sel_s) begin
               done_d[g_q] = 1'b1;
               cnt_d       = {CNT_W{1'b0}};
            end else if (wd_exp_s) begin
               done_d[g_q] = 1'b1;
               err_d       = 1'b1;
               erst_d      = 1'b1;
               cnt_d       = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_GAP:  cnt_d = cnt_q + CNT_W'(1);
         default: cnt_d = {CNT_W{1'b0}};
      endcase
   end

   // Engine reset is held high during chip reset so engines abort immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_q     <= 1'b0;
         op_q    <= OP_RDREG;
         casig_q <= 48'd0;
         start_q <= 4'd0;
         done_q  <= 2'd0;
         err_q   <= 1'b0;
         erst_q  <= 1'b1;
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         g_q     <= g_d;
         op_q    <= op_d;
         casig_q <= casig_d;
         start_q <= start_d;
         done_q  <= done_d;
         err_q   <= err_d;
         erst_q  <= erst_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request accept and PHY bus mux; the PHY idles outside LAUNCH/BUSY.
   always_comb begin
      req_ready    = 2'b00;
      phy_csn      = 1'b1;
      phy_oe       = 1'b0;
      phy_oe_clk   = 1'b0;
      phy_datain   = 16'd0;
      phy_rwds_out = 1'b0;
      phy_rwds_oe  = 1'b0;
      if (take_s && rst_n) begin
         req_ready[grant_s] = 1'b1;
      end else begin
         req_ready = 2'b00;
      end
      if ((state_q == ST_LAUNCH) || (state_q == ST_BUSY)) begin
         phy_csn    = eng_csn[op_idx_s];
         phy_oe     = eng_oe[op_idx_s];
         phy_oe_clk = eng_oe_clk[op_idx_s];
         phy_datain = eng_datain[{op_idx_s, 4'b0000} +: 16];
         if (op_q == OP_WRMEM) begin
            phy_rwds_out = eng_rwds_out;
            phy_rwds_oe  = eng_rwds_oe;
         end else begin
            phy_rwds_out = 1'b0;
            phy_rwds_oe  = 1'b0;
         end
      end else begin
         phy_csn = 1'b1;
      end
   end

endmodule

// File: tb/tb_hyperram_cmd_sched.sv
// Self-checking bench for hyperram_cmd_sched: scoreboard of expected engine starts and
// responses, plus per-scenario timing checks of the PHY mux, watchdog and gap.
module tb_hyperram_cmd_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid, req_ready, rsp_done;
   logic [3:0]  req_op, eng_start, eng_end, eng_csn, eng_oe, eng_oe_clk;
   logic [63:0] req_addr, eng_datain;
   logic        rsp_err, eng_rst, eng_rwds_out, eng_rwds_oe;
   logic [47:0] eng_casig;
   logic        phy_csn, phy_oe, phy_oe_clk, phy_rwds_out, phy_rwds_oe;
   logic [15:0] phy_datain;

   int errors = 0;
   int checks = 0;

   typedef struct {logic [3:0] start; logic [47:0] ca;} st_exp_t;
   typedef struct {logic [1:0] done; logic err; logic erst;} dn_exp_t;
   st_exp_t st_q[$];
   dn_exp_t dn_q[$];

   always #5 clk = ~clk;

   hyperram_cmd_sched #(
      .ADDR_W(32), .GAP_CYCLES(4), .TIMEOUT_CYCLES(64), .LINEAR_BURST(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr), .rsp_done(rsp_done), .rsp_err(rsp_err),
      .eng_casig(eng_casig), .eng_start(eng_start), .eng_end(eng_end), .eng_rst(eng_rst),
      .eng_csn(eng_csn), .eng_oe(eng_oe), .eng_oe_clk(eng_oe_clk), .eng_datain(eng_datain),
      .eng_rwds_out(eng_rwds_out), .eng_rwds_oe(eng_rwds_oe),
      .phy_csn(phy_csn), .phy_oe(phy_oe), .phy_oe_clk(phy_oe_clk), .phy_datain(phy_datain),
      .phy_rwds_out(phy_rwds_out), .phy_rwds_oe(phy_rwds_oe)
   );

   function automatic logic [47:0] exp_ca(input logic [1:0] op, input logic [31:0] a);
      logic rd, rg;
      rd = (op == 2'd0) || (op == 2'd3);
      rg = (op == 2'd0) || (op == 2'd2);
      return {rd, rg, 1'b1, a[31:3], 13'd0, a[2:0]};
   endfunction

   function automatic logic [15:0] data_of(input logic [1:0] op);
      case (op)
         2'd0:    return 16'hD000;
         2'd1:    return 16'hD111;
         2'd2:    return 16'hD222;
         default: return 16'hD333;
      endcase
   endfunction

   // Scoreboard: every start pulse and response pulse must match the oldest expectation.
   always @(negedge clk) begin
      st_exp_t s;
      dn_exp_t d;
      if (eng_start !== 4'd0) begin
         checks++;
         if (st_q.size() == 0) begin
            errors++;
            $display("FAIL start_unexpected: eng_start=%b, none expected", eng_start);
         end else begin
            s = st_q.pop_front();
            if (eng_start !== s.start || eng_casig !== s.ca) begin
               errors++;
               $display("FAIL start_ca: got start=%b ca=%h, expected start=%b ca=%h",
                        eng_start, eng_casig, s.start, s.ca);
            end
         end
      end
      if (rsp_done !== 2'd0) begin
         checks++;
         if (dn_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: rsp_done=%b, none expected", rsp_done);
         end else begin
            d = dn_q.pop_front();
            if (rsp_done !== d.done || rsp_err !== d.err || eng_rst !== d.erst) begin
               errors++;
               $display("FAIL done_rsp: got done=%b err=%b eng_rst=%b, expected done=%b err=%b eng_rst=%b",
                        rsp_done, rsp_err, eng_rst, d.done, d.err, d.erst);
            end
         end
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; req_valid = 2'b00; eng_end = 4'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // One transaction: request, launch, BUSY tracking for end_at cycles (or full watchdog), response.
   task automatic xact(input int r, input logic [1:0] op, input logic [31:0] addr, input logic [47:0] ca,
                       input int end_at, input logic exp_err, input int spur_at, input logic [3:0] spur_mask);
      bit ok;
      int last;
      st_exp_t s;
      dn_exp_t d;
      s.start = 4'b0001 << op; s.ca = ca; st_q.push_back(s);
      d.done = 2'b01 << r; d.err = exp_err; d.erst = exp_err; dn_q.push_back(d);
      if (r == 0) begin req_op[1:0] = op; req_addr[31:0] = addr; end
      else        begin req_op[3:2] = op; req_addr[63:32] = addr; end
      req_valid[r] = 1'b1;
      #1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (req_ready[r]) begin ok = 1'b1; break; end
         @(negedge clk); #1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL grant_wait: req%0d req_ready=%b, required 1 within 100 cycles", r, req_ready);
         req_valid[r] = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid[r] = 1'b0;
      checks++;
      if (eng_start !== (4'b0001 << op)) begin
         errors++;
         $display("FAIL launch: eng_start=%b, required %b", eng_start, 4'b0001 << op);
      end
      last = (end_at < 0) ? 64 : end_at;
      for (int n = 1; n <= last; n++) begin
         @(negedge clk);
         checks++;
         if (phy_csn !== 1'b0 || phy_oe !== eng_oe[op] || phy_datain !== data_of(op) ||
             phy_rwds_out !== (op == 2'd1) || rsp_done !== 2'b00 || eng_start !== 4'd0) begin
            errors++;
            $display("FAIL busy_track n=%0d: csn=%b oe=%b data=%h rwds=%b done=%b start=%b, required csn=0 oe=%b data=%h rwds=%b done=00 start=0000",
                     n, phy_csn, phy_oe, phy_datain, phy_rwds_out, rsp_done, eng_start,
                     eng_oe[op], data_of(op), (op == 2'd1));
         end
         eng_end = 4'd0;
         if (n == spur_at) eng_end = spur_mask;
         if (n == end_at)  eng_end[op] = 1'b1;
      end
      @(negedge clk);
      eng_end = 4'd0;
      checks++;
      if (rsp_done !== (2'b01 << r) || rsp_err !== exp_err || phy_csn !== 1'b1) begin
         errors++;
         $display("FAIL done_cycle: done=%b err=%b csn=%b, required done=%b err=%b csn=1",
                  rsp_done, rsp_err, phy_csn, 2'b01 << r, exp_err);
      end
   endtask

   task automatic test_reset();
      #2;
      rst_n = 1'b0; req_valid = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: %b, required 00", req_ready); end
      checks++;
      if ({rsp_done, rsp_err} !== 3'b000) begin
         errors++; $display("FAIL reset_rsp: done=%b err=%b, required 0", rsp_done, rsp_err);
      end
      checks++;
      if (eng_start !== 4'd0 || eng_casig !== 48'd0) begin
         errors++; $display("FAIL reset_eng: start=%b ca=%h, required 0", eng_start, eng_casig);
      end
      checks++;
      if (phy_csn !== 1'b1 || phy_oe !== 1'b0 || phy_oe_clk !== 1'b0 || phy_datain !== 16'd0 ||
          phy_rwds_out !== 1'b0 || phy_rwds_oe !== 1'b0) begin
         errors++; $display("FAIL reset_phy: csn=%b oe=%b data=%h, required csn=1 others 0", phy_csn, phy_oe, phy_datain);
      end
      checks++;
      if (eng_rst !== 1'b1) begin errors++; $display("FAIL reset_eng_rst: %b, required 1", eng_rst); end
      repeat (2) @(negedge clk);
      req_valid = 2'b00; rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_rdmem();
      xact(0, 2'd3, 32'h0000_0123, 48'hA000_0024_0003, 3, 1'b0, 0, 4'd0);
   endtask

   task automatic test_back_to_back();
      st_exp_t s;
      dn_exp_t d;
      bit ok;
      time t_prev;
      logic [1:0] op;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         s.start = (i % 2 == 0) ? 4'b0010 : 4'b0001;
         s.ca    = (i % 2 == 0) ? exp_ca(2'd1, 32'h0000_0100) : exp_ca(2'd0, 32'h0000_0200);
         st_q.push_back(s);
         d.done = (i % 2 == 0) ? 2'b01 : 2'b10; d.err = 1'b0; d.erst = 1'b0;
         dn_q.push_back(d);
      end
      req_op = {2'd0, 2'd1}; req_addr = {32'h0000_0200, 32'h0000_0100}; req_valid = 2'b11;
      t_prev = 0;
      for (int i = 0; i < 4; i++) begin
         ok = 1'b0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (eng_start !== 4'd0) begin ok = 1'b1; break; end
         end
         checks++;
         if (!ok) begin errors++; $display("FAIL b2b_start%0d: eng_start=%b, required a pulse within 20 cycles", i, eng_start); end
         if (i > 0) begin
            checks++;
            if (($time - t_prev) != 70) begin
               errors++; $display("FAIL b2b_spacing%0d: %0d time units, required 70 (7 cycles)", i, $time - t_prev);
            end
         end
         t_prev = $time;
         if (i == 3) req_valid = 2'b00;
         op = (i % 2 == 0) ? 2'd1 : 2'd0;
         @(negedge clk); eng_end[op] = 1'b1;
         @(negedge clk); eng_end = 4'd0;
      end
   endtask

   task automatic test_timeout();
      xact(1, 2'd2, 32'h0000_0040, exp_ca(2'd2, 32'h0000_0040), -1, 1'b1, 0, 4'd0);
      req_op[1:0] = 2'd3; req_addr[31:0] = 32'h0000_1000; req_valid[0] = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 2'b00 || phy_csn !== 1'b1) begin
            errors++; $display("FAIL gap_hold%0d: ready=%b csn=%b, required ready=00 csn=1", k, req_ready, phy_csn);
         end
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL gap_release: ready=%b, required 01", req_ready); end
      xact(0, 2'd3, 32'h0000_1000, exp_ca(2'd3, 32'h0000_1000), 2, 1'b0, 0, 4'd0);
   endtask

   task automatic test_end_vs_timeout();
      xact(0, 2'd0, 32'h0000_0007, exp_ca(2'd0, 32'h0000_0007), 64, 1'b0, 0, 4'd0);
   endtask

   task automatic test_spurious_end();
      xact(1, 2'd1, 32'h0ABC_DEF8, exp_ca(2'd1, 32'h0ABC_DEF8), 5, 1'b0, 2, 4'b1101);
   endtask

   task automatic test_reset_mid_busy();
      st_exp_t s;
      dn_exp_t d;
      bit ok;
      s.start = 4'b1000; s.ca = exp_ca(2'd3, 32'h0000_2222); st_q.push_back(s);
      req_op[3:2] = 2'd3; req_addr[63:32] = 32'h0000_2222; req_valid[1] = 1'b1;
      #1;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (req_ready[1]) begin ok = 1'b1; break; end
         @(negedge clk); #1;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL rst_busy_grant: ready=%b, required 10", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (phy_csn !== 1'b1 || eng_rst !== 1'b1 || rsp_done !== 2'b00) begin
         errors++; $display("FAIL rst_busy_async: csn=%b eng_rst=%b done=%b, required 1 1 00", phy_csn, eng_rst, rsp_done);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (rsp_done !== 2'b00) begin errors++; $display("FAIL rst_busy_nodone: done=%b, required 00", rsp_done); end
      end
      rst_n = 1'b1;
      req_op = {2'd3, 2'd0}; req_addr = {32'h0000_3333, 32'h0000_4444}; req_valid = 2'b11;
      s.start = 4'b0001; s.ca = exp_ca(2'd0, 32'h0000_4444); st_q.push_back(s);
      d.done = 2'b01; d.err = 1'b0; d.erst = 1'b0; dn_q.push_back(d);
      #1;
      checks++;
      if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_first_grant: ready=%b, required 01", req_ready); end
      @(negedge clk); req_valid = 2'b00;
      @(negedge clk); eng_end = 4'b0001;
      @(negedge clk); eng_end = 4'd0;
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish in bound");
      $fatal(1, "global timeout");
   end

   initial begin
      rst_n = 1'b1; req_valid = 2'b00; req_op = 4'd0; req_addr = 64'd0; eng_end = 4'd0;
      eng_csn = 4'b0000; eng_oe = 4'b0101; eng_oe_clk = 4'b0011;
      eng_datain = {16'hD333, 16'hD222, 16'hD111, 16'hD000};
      eng_rwds_out = 1'b1; eng_rwds_oe = 1'b1;
      test_reset();
      test_rdmem();
      test_back_to_back();
      test_timeout();
      test_end_vs_timeout();
      test_spurious_end();
      test_reset_mid_busy();
      checks++;
      if (st_q.size() != 0 || dn_q.size() != 0) begin
         errors++; $display("FAIL leftover: starts=%0d dones=%0d still expected, required 0 0", st_q.size(), dn_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
